// File: rtl/gemm_feed_sequencer.sv
`default_nettype none
// ============================================================================
// Module : gemm_feed_sequencer
// Streams weight, input and partial-sum rows into a systolic array and writes results back.
// Rev    : 1.0
// ============================================================================
module gemm_feed_sequencer #(
    parameter int N  = 4,
    parameter int DW = 16
) (
    input  logic                   CLK,
    input  logic                   nrst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_wbase,
    input  logic [7:0]             cmd_ibase,
    input  logic [7:0]             cmd_pbase,
    input  logic [7:0]             cmd_obase,
    output logic                   rd_en,
    output logic [7:0]             rd_addr,
    input  logic [N*DW-1:0]        rd_data,
    output logic                   wr_en,
    output logic [7:0]             wr_addr,
    output logic [N*DW-1:0]        wr_data,
    input  logic                   fifo_has_space,
    input  logic                   drained,
    output logic                   weight_en,
    output logic                   input_en,
    output logic                   partial_en,
    output logic [$clog2(N)-1:0]   row_in_en,
    output logic [$clog2(N)-1:0]   row_ps_en,
    output logic [N*DW-1:0]        array_in,
    output logic [N*DW-1:0]        array_in_partials,
    input  logic                   out_en,
    input  logic [$clog2(N)-1:0]   row_out,
    input  logic [N*DW-1:0]        array_output,
    output logic                   gemm_complete
);
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam logic [RW-1:0] c_LAST_ROW = RW'(N - 1);
    localparam logic [CW-1:0] c_OUT_FULL = CW'(N);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_W_RD   = 4'd1,
        ST_W_CAP  = 4'd2,
        ST_W_ISS  = 4'd3,
        ST_I_RD   = 4'd4,
        ST_I_CAP  = 4'd5,
        ST_P_CAP  = 4'd6,
        ST_IP_ISS = 4'd7,
        ST_DRAIN  = 4'd8,
        ST_DONE   = 4'd9
    } state_t;

    state_t            r_state;
    logic [RW-1:0]     r_row;
    logic [CW-1:0]     r_out_cnt;
    logic [7:0]        r_wbase, r_ibase, r_pbase, r_obase;
    logic [N*DW-1:0]   r_wbuf, r_ibuf, r_pbuf;
    logic              r_cmd_ready, r_rd_en, r_wr_en, r_complete;
    logic              r_weight_en, r_input_en, r_partial_en;
    logic [7:0]        r_rd_addr, r_wr_addr;
    logic [N*DW-1:0]   r_wr_data, r_array_in, r_array_ps;
    logic [RW-1:0]     r_row_in, r_row_ps;
    logic              w_row_last;

    assign w_row_last = (r_row == c_LAST_ROW);

    // Outputs are registered: each is set on the edge that enters the state that owns it.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_wbase      <= '0;
            r_ibase      <= '0;
            r_pbase      <= '0;
            r_obase      <= '0;
            r_wbuf       <= '0;
            r_ibuf       <= '0;
            r_pbuf       <= '0;
            r_cmd_ready  <= 1'b1;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_weight_en  <= 1'b0;
            r_input_en   <= 1'b0;
            r_partial_en <= 1'b0;
            r_row_in     <= '0;
            r_row_ps     <= '0;
            r_array_in   <= '0;
            r_array_ps   <= '0;
            r_complete   <= 1'b0;
        end else begin
            r_rd_en      <= 1'b0;
            r_weight_en  <= 1'b0;
            r_input_en   <= 1'b0;
            r_partial_en <= 1'b0;
            r_complete   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_wbase     <= cmd_wbase;
                        r_ibase     <= cmd_ibase;
                        r_pbase     <= cmd_pbase;
                        r_obase     <= cmd_obase;
                        r_row       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_rd_en     <= 1'b1;
                        r_rd_addr   <= cmd_wbase;
                        r_state     <= ST_W_RD;
                    end
                end
                ST_W_RD:  r_state <= ST_W_CAP;
                ST_W_CAP: begin
                    r_wbuf  <= rd_data;
                    r_state <= ST_W_ISS;
                end
                ST_W_ISS: begin
                    if (fifo_has_space) begin
                        r_weight_en <= 1'b1;
                        r_row_in    <= r_row;
                        r_array_in  <= r_wbuf;
                        r_rd_en     <= 1'b1;
                        if (w_row_last) begin
                            r_row     <= '0;
                            r_rd_addr <= r_ibase;
                            r_state   <= ST_I_RD;
                        end else begin
                            r_row     <= r_row + RW'(1);
                            r_rd_addr <= r_wbase + 8'(r_row) + 8'd1;
                            r_state   <= ST_W_RD;
                        end
                    end
                end
                ST_I_RD: begin
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= r_pbase + 8'(r_row);
                    r_state   <= ST_I_CAP;
                end
                ST_I_CAP: begin
                    r_ibuf  <= rd_data;
                    r_state <= ST_P_CAP;
                end
                ST_P_CAP: begin
                    r_pbuf  <= rd_data;
                    r_state <= ST_IP_ISS;
                end
                ST_IP_ISS: begin
                    if (fifo_has_space) begin
                        r_input_en   <= 1'b1;
                        r_partial_en <= 1'b1;
                        r_row_in     <= r_row;
                        r_row_ps     <= r_row;
                        r_array_in   <= r_ibuf;
                        r_array_ps   <= r_pbuf;
                        if (w_row_last) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_row     <= r_row + RW'(1);
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= r_ibase + 8'(r_row) + 8'd1;
                            r_state   <= ST_I_RD;
                        end
                    end
                end
                // An out_en seen this cycle is a write still to be issued, so it blocks completion.
                ST_DRAIN: begin
                    if (drained && (r_out_cnt == c_OUT_FULL) && !out_en) begin
                        r_complete <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_out_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_wr_en <= 1'b0;
            if (cmd_valid) begin
                r_out_cnt <= '0;
            end
        end else begin
            r_wr_en <= out_en;
            if (out_en) begin
                r_wr_addr <= r_obase + 8'(row_out);
                r_wr_data <= array_output;
                if (r_out_cnt != c_OUT_FULL) begin
                    r_out_cnt <= r_out_cnt + CW'(1);
                end
            end
        end
    end

    assign cmd_ready         = r_cmd_ready;
    assign rd_en             = r_rd_en;
    assign rd_addr           = r_rd_addr;
    assign wr_en             = r_wr_en;
    assign wr_addr           = r_wr_addr;
    assign wr_data           = r_wr_data;
    assign weight_en         = r_weight_en;
    assign input_en          = r_input_en;
    assign partial_en        = r_partial_en;
    assign row_in_en         = r_row_in;
    assign row_ps_en         = r_row_ps;
    assign array_in          = r_array_in;
    assign array_in_partials = r_array_ps;
    assign gemm_complete     = r_complete;

endmodule
`default_nettype wire

// File: tb/tb_gemm_feed_sequencer.sv
`default_nettype none
// Testbench for gemm_feed_sequencer: scratchpad model, expected-event queues and a
// negedge monitor that pops and compares every read, issue, write and completion.
module tb_gemm_feed_sequencer;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int W  = N * DW;
    localparam int RW = $clog2(N);

    logic            CLK = 1'b0;
    logic            nrst = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [7:0]      cmd_wbase = '0, cmd_ibase = '0, cmd_pbase = '0, cmd_obase = '0;
    logic            rd_en;
    logic [7:0]      rd_addr;
    logic [W-1:0]    rd_data = '0;
    logic            wr_en;
    logic [7:0]      wr_addr;
    logic [W-1:0]    wr_data;
    logic            fifo_has_space = 1'b1;
    logic            drained = 1'b0;
    logic            weight_en, input_en, partial_en;
    logic [RW-1:0]   row_in_en, row_ps_en;
    logic [W-1:0]    array_in, array_in_partials;
    logic            out_en = 1'b0;
    logic [RW-1:0]   row_out = '0;
    logic [W-1:0]    array_output = '0;
    logic            gemm_complete;

    gemm_feed_sequencer #(.N(N), .DW(DW)) dut (
        .CLK(CLK), .nrst(nrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wbase(cmd_wbase), .cmd_ibase(cmd_ibase), .cmd_pbase(cmd_pbase), .cmd_obase(cmd_obase),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .fifo_has_space(fifo_has_space), .drained(drained),
        .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
        .row_in_en(row_in_en), .row_ps_en(row_ps_en),
        .array_in(array_in), .array_in_partials(array_in_partials),
        .out_en(out_en), .row_out(row_out), .array_output(array_output),
        .gemm_complete(gemm_complete)
    );

    always #5 CLK = ~CLK;

    typedef struct { int row; logic [W-1:0] d; logic [W-1:0] p; int t; } iss_t;
    typedef struct { logic [7:0] a; logic [W-1:0] d; } wr_t;

    logic [W-1:0] mem [256];
    logic [7:0]   exp_rd [$];
    iss_t         exp_w  [$];
    iss_t         exp_i  [$];
    wr_t          exp_wr [$];
    int           exp_done [$];

    int           n_vec = 0, n_err = 0;
    int           cyc = 0, t_acc = 0, rel_m = 0, space_mode = 0;
    bit           stall_chk = 1'b0;
    logic [W-1:0] stall_hold = '0;
    bit           pend = 1'b0;
    logic [7:0]   pend_addr = '0;
    iss_t         em;
    wr_t          ew;
    int           td;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scratchpad: data for a read appears one cycle after rd_en, then the monitor.
    always @(negedge CLK) begin
        rel_m = cyc - t_acc;
        if (!nrst) begin
            pend = 1'b0;
        end else begin
            if (pend) rd_data = mem[pend_addr];
            pend      = rd_en;
            pend_addr = rd_addr;
            if (rd_en) begin
                if (exp_rd.size() == 0) chk("rd_en_unexpected", W'(rd_en), '0);
                else chk("rd_addr", W'(rd_addr), W'(exp_rd.pop_front()));
            end
            if (weight_en) begin
                if (exp_w.size() == 0) chk("weight_en_unexpected", W'(weight_en), '0);
                else begin
                    em = exp_w.pop_front();
                    chk("w_row", W'(row_in_en), W'(em.row));
                    chk("w_data", array_in, em.d);
                    if (em.t >= 0) chk("w_cycle", W'(rel_m), W'(em.t));
                end
            end
            if (input_en || partial_en) begin
                if (exp_i.size() == 0) chk("input_en_unexpected", W'({input_en, partial_en}), '0);
                else begin
                    em = exp_i.pop_front();
                    chk("ip_en_pair", W'({input_en, partial_en}), W'(2'b11));
                    chk("i_row", W'(row_in_en), W'(em.row));
                    chk("p_row", W'(row_ps_en), W'(em.row));
                    chk("i_data", array_in, em.d);
                    chk("p_data", array_in_partials, em.p);
                    if (em.t >= 0) chk("i_cycle", W'(rel_m), W'(em.t));
                end
            end
            if (wr_en) begin
                if (exp_wr.size() == 0) chk("wr_en_unexpected", W'(wr_en), '0);
                else begin
                    ew = exp_wr.pop_front();
                    chk("wr_addr", W'(wr_addr), W'(ew.a));
                    chk("wr_data", wr_data, ew.d);
                end
            end
            if (gemm_complete) begin
                if (exp_done.size() == 0) chk("complete_unexpected", W'(gemm_complete), '0);
                else begin
                    td = exp_done.pop_front();
                    if (td >= 0) chk("complete_cycle", W'(rel_m), W'(td));
                end
            end
            if (stall_chk && rel_m >= 9 && rel_m <= 13) begin
                chk("stall_weight_en", W'(weight_en), '0);
                chk("stall_array_in", array_in, stall_hold);
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            case (space_mode)
                0:       fifo_has_space = 1'b1;
                1:       fifo_has_space = ($urandom_range(9) < 7);
                2:       fifo_has_space = !(((cyc - t_acc) >= 8) && ((cyc - t_acc) <= 12));
                default: fifo_has_space = 1'b0;
            endcase
        end
    end

    task automatic flush_queues();
        exp_rd.delete(); exp_w.delete(); exp_i.delete(); exp_wr.delete(); exp_done.delete();
    endtask

    // mode 0: random space/outputs; 1: nominal timed; 2: 5-cycle stall at weight row 2;
    // 3: drained raised after 3 outputs, 4th output late.
    task automatic run_cmd(input logic [7:0] wb, ib, pb, ob, input int mode);
        iss_t       e;
        wr_t        w;
        logic [7:0] a8;
        int         stall;
        bit         timed;
        timed = (mode != 0);
        stall = (mode == 2) ? 5 : 0;
        for (int a = 0; a < 256; a++) mem[a] = {$urandom, $urandom};
        for (int r = 0; r < N; r++) begin
            a8 = wb + 8'(r);
            exp_rd.push_back(a8);
            e.row = r; e.d = mem[a8]; e.p = '0;
            e.t = timed ? 3 * (r + 1) + ((r >= 2) ? stall : 0) : -1;
            exp_w.push_back(e);
        end
        for (int r = 0; r < N; r++) begin
            a8 = ib + 8'(r); exp_rd.push_back(a8); e.d = mem[a8];
            a8 = pb + 8'(r); exp_rd.push_back(a8); e.p = mem[a8];
            e.row = r;
            e.t = timed ? 3 * N + 4 * (r + 1) + stall : -1;
            exp_i.push_back(e);
        end
        a8 = wb + 8'd1;
        stall_hold = mem[a8];
        if (mode != 3) exp_done.push_back(-1);
        space_mode = (mode == 0) ? 1 : ((mode == 2) ? 2 : 0);

        @(negedge CLK);
        chk("cmd_ready_idle", W'(cmd_ready), W'(1'b1));
        t_acc = cyc + 1;
        cmd_valid = 1'b1;
        cmd_wbase = wb; cmd_ibase = ib; cmd_pbase = pb; cmd_obase = ob;
        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_wbase = 8'($urandom); cmd_ibase = 8'($urandom);
        cmd_pbase = 8'($urandom); cmd_obase = 8'($urandom);
        stall_chk = (mode == 2);
        @(negedge CLK);
        chk("cmd_ready_busy", W'(cmd_ready), '0);

        fork
            begin
                int tgt;
                tgt = 1;
                for (int k = 0; k < N; k++) begin
                    if (mode == 0) tgt = tgt + $urandom_range(2, 12);
                    else if (mode == 3 && k == 3) tgt = 40;
                    else tgt = 2 + 3 * k;
                    while ((cyc - t_acc) < tgt) @(negedge CLK);
                    out_en = 1'b1;
                    row_out = RW'($urandom);
                    array_output = {$urandom, $urandom};
                    w.a = ob + 8'(row_out);
                    w.d = array_output;
                    exp_wr.push_back(w);
                    if (mode == 3 && k == 3) exp_done.push_back(tgt + 2);
                    @(negedge CLK);
                    out_en = 1'b0;
                    if (mode == 3 && k == 2) drained = 1'b1;
                end
                drained = 1'b1;
            end
            begin
                while ((cyc - t_acc) < 10) @(negedge CLK);
                cmd_valid = 1'b1;
                cmd_wbase = 8'($urandom); cmd_ibase = 8'($urandom);
                cmd_pbase = 8'($urandom); cmd_obase = 8'($urandom);
                repeat (3) @(negedge CLK);
                cmd_valid = 1'b0;
            end
        join

        for (int i = 0; i < 400 && exp_done.size() != 0; i++) @(negedge CLK);
        chk("complete_pending", W'(exp_done.size()), '0);
        chk("reads_missing", W'(exp_rd.size()), '0);
        chk("weights_missing", W'(exp_w.size()), '0);
        chk("inputs_missing", W'(exp_i.size()), '0);
        chk("writes_missing", W'(exp_wr.size()), '0);
        flush_queues();
        drained = 1'b0;
        stall_chk = 1'b0;
        space_mode = 0;

        @(negedge CLK);
        chk("cmd_ready_after", W'(cmd_ready), W'(1'b1));
        out_en = 1'b1;
        row_out = RW'($urandom);
        array_output = {$urandom, $urandom};
        @(negedge CLK);
        out_en = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic reset_mid_w_iss(input logic [7:0] wb);
        space_mode = 3;
        for (int a = 0; a < 256; a++) mem[a] = {$urandom, $urandom};
        exp_rd.push_back(wb);
        @(negedge CLK);
        t_acc = cyc + 1;
        cmd_valid = 1'b1;
        cmd_wbase = wb; cmd_ibase = 8'h55; cmd_pbase = 8'h66; cmd_obase = 8'h77;
        @(negedge CLK);
        cmd_valid = 1'b0;
        while ((cyc - t_acc) < 4) @(negedge CLK);
        chk("stuck_cmd_ready", W'(cmd_ready), '0);
        nrst = 1'b0;
        out_en = 1'b1;
        #1;
        chk("rst_cmd_ready", W'(cmd_ready), W'(1'b1));
        chk("rst_enables", W'({weight_en, input_en, partial_en, rd_en}), '0);
        chk("rst_wr_en", W'(wr_en), '0);
        chk("rst_complete", W'(gemm_complete), '0);
        chk("rst_array_in", array_in, '0);
        chk("rst_rd_addr", W'(rd_addr), '0);
        @(negedge CLK);
        out_en = 1'b0;
        chk("reads_missing_rst", W'(exp_rd.size()), '0);
        flush_queues();
        nrst = 1'b1;
        space_mode = 0;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("init_cmd_ready", W'(cmd_ready), W'(1'b1));
        chk("init_enables", W'({weight_en, input_en, partial_en, rd_en, wr_en, gemm_complete}), '0);
        chk("init_array_in", array_in, '0);
        nrst = 1'b1;

        @(negedge CLK);
        out_en = 1'b1;
        array_output = {$urandom, $urandom};
        @(negedge CLK);
        out_en = 1'b0;
        repeat (2) @(negedge CLK);

        run_cmd(8'h10, 8'h20, 8'h30, 8'h40, 1);
        run_cmd(8'hFE, 8'($urandom), 8'($urandom), 8'($urandom), 1);
        run_cmd(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2);
        run_cmd(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 3);
        reset_mid_w_iss(8'h90);
        run_cmd(8'h10, 8'h20, 8'h30, 8'h40, 1);
        for (int i = 0; i < 6; i++)
            run_cmd(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected under 50000", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
